memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/memory_access_stage.sv | 110 +++++++++++
 tb/tb_memory_access_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, instruction classes
// and small decode helpers used across pipeline stages.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_XOR    = 4'd5,
    OP_SLT    = 4'd6,
    OP_BRANCH = 4'd7,
    OP_LOAD   = 4'd8,
    OP_STORE  = 4'd9
  } opcode_t;

  function automatic logic is_mem(opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/memory_access_stage.sv
// MEM stage: issues word loads/stores to data memory and
// hands results to writeback over a valid/ready handshake.
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_rs2_data,
  input  logic                  ex_zero,
  input  opcode_t               ex_opcode,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_result,
  output opcode_t               wb_opcode,
  output logic                  wb_zero,
  output logic                  wb_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } state_t;

  state_t state;

  logic ex_mem;
  logic ex_aligned;

  assign ex_mem     = is_mem(ex_opcode);
  assign ex_aligned = (ex_alu_result[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ex_ready    <= 1'b1;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_result   <= '0;
      wb_opcode   <= OP_NOP;
      wb_zero     <= 1'b0;
      wb_misalign <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_valid) begin
            ex_ready    <= 1'b0;
            dmem_addr   <= ex_alu_result;
            dmem_wdata  <= ex_rs2_data;
            dmem_we     <= (ex_opcode == OP_STORE);
            wb_result   <= ex_alu_result;
            wb_opcode   <= ex_opcode;
            wb_zero     <= ex_zero;
            unique case (1'b1)
              ex_mem && ex_aligned: begin
                state       <= ACCESS;
                dmem_req    <= 1'b1;
                wb_misalign <= 1'b0;
              end
              default: begin
                // misaligned memory ops never reach the bus
                state       <= HOLD;
                wb_valid    <= 1'b1;
                wb_misalign <= ex_mem;
              end
            endcase
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state    <= HOLD;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            if (!dmem_we) begin
              wb_result <= dmem_rdata;
            end
          end
        end
        HOLD: begin
          if (wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            ex_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
          dmem_req <= 1'b0;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage: the bench plays
// execute, data memory and writeback around a transaction model.
module tb_memory_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic        ex_zero;
  opcode_t     ex_opcode;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  opcode_t     wb_opcode;
  logic        wb_zero;
  logic        wb_misalign;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  memory_access_stage #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_alu_result(ex_alu_result),
    .ex_rs2_data  (ex_rs2_data),
    .ex_zero      (ex_zero),
    .ex_opcode    (ex_opcode),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_result    (wb_result),
    .wb_opcode    (wb_opcode),
    .wb_zero      (wb_zero),
    .wb_misalign  (wb_misalign)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One instruction end to end; all expectations come from the
  // instruction itself and from the bench's memory image.
  task automatic run_txn(input opcode_t     op,
                         input logic [31:0] addr,
                         input logic [31:0] data,
                         input logic        zero,
                         input int          ack_dly,
                         input int          stall);
    logic        is_ls;
    logic        mis;
    logic        goes_to_bus;
    logic [31:0] exp_res;
    logic [31:0] rd;
    is_ls       = (op == OP_LOAD) || (op == OP_STORE);
    mis         = is_ls && (addr % 4 != 0);
    goes_to_bus = is_ls && !mis;
    exp_res     = addr;

    @(negedge clk);
    check("ex_ready_idle", 32'(ex_ready), 32'd1);
    ex_valid      = 1'b1;
    ex_opcode     = op;
    ex_alu_result = addr;
    ex_rs2_data   = data;
    ex_zero       = zero;
    @(negedge clk);
    ex_valid      = 1'b0;
    ex_alu_result = $urandom;
    ex_rs2_data   = $urandom;

    if (goes_to_bus) begin
      for (int i = 0; i <= ack_dly; i++) begin
        check("acc_req", 32'(dmem_req), 32'd1);
        check("acc_we", 32'(dmem_we), 32'(op == OP_STORE));
        check("acc_addr", dmem_addr, addr);
        if (op == OP_STORE) check("acc_wdata", dmem_wdata, data);
        check("acc_wbv", 32'(wb_valid), 32'd0);
        check("acc_rdy", 32'(ex_ready), 32'd0);
        if (i == ack_dly) begin
          if (op == OP_LOAD) begin
            if (mem.exists(addr)) rd = mem[addr];
            else begin
              rd = $urandom;
              mem[addr] = rd;
            end
            exp_res = rd;
          end else begin
            mem[addr] = data;
            rd = $urandom;
          end
          dmem_ack   = 1'b1;
          dmem_rdata = rd;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
      end
    end else begin
      check("no_req", 32'(dmem_req), 32'd0);
    end

    for (int s = 0; s <= stall; s++) begin
      check("wb_valid", 32'(wb_valid), 32'd1);
      check("wb_result", wb_result, exp_res);
      check("wb_opcode", 32'(wb_opcode), 32'(op));
      check("wb_zero", 32'(wb_zero), 32'(zero));
      check("wb_misalign", 32'(wb_misalign), 32'(mis));
      check("hold_req", 32'(dmem_req), 32'd0);
      check("hold_rdy", 32'(ex_ready), 32'd0);
      // stray acks while not accessing must be ignored
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      if (s == stall) wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      dmem_ack = 1'b0;
    end
    check("wb_drop", 32'(wb_valid), 32'd0);
  endtask

  initial begin
    opcode_t     op;
    logic [3:0]  r;
    logic [31:0] a;
    rst_n         = 1'b0;
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_rs2_data   = '0;
    ex_zero       = 1'b0;
    ex_opcode     = OP_NOP;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    wb_ready      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_res", wb_result, 32'd0);
    check("rst_op", 32'(wb_opcode), 32'(OP_NOP));
    check("rst_zero", 32'(wb_zero), 32'd0);
    check("rst_mis", 32'(wb_misalign), 32'd0);
    rst_n = 1'b1;

    run_txn(OP_ADD, 32'h10, 32'h0, 1'b0, 0, 0);
    run_txn(OP_STORE, 32'h100, 32'hDEADBEEF, 1'b0, 2, 0);
    mem[32'h200] = 32'h12345678;
    run_txn(OP_LOAD, 32'h200, 32'h0, 1'b1, 0, 0);
    run_txn(OP_LOAD, 32'h203, 32'h0, 1'b0, 0, 0);
    run_txn(OP_SUB, 32'hCAFE0000, 32'h1, 1'b1, 0, 5);
    run_txn(OP_LOAD, 32'h100, 32'h0, 1'b0, 1, 0);

    // reset in the middle of an access
    @(negedge clk);
    ex_valid      = 1'b1;
    ex_opcode     = OP_LOAD;
    ex_alu_result = 32'h300;
    @(negedge clk);
    ex_valid = 1'b0;
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_wbv", 32'(wb_valid), 32'd0);
    rst_n    = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_wbv", 32'(wb_valid), 32'd0);
      check("post_rst_req", 32'(dmem_req), 32'd0);
      check("post_rst_rdy", 32'(ex_ready), 32'd1);
    end
    dmem_ack = 1'b0;

    for (int n = 0; n < 200; n++) begin
      r  = 4'($urandom_range(0, 9));
      op = opcode_t'(r);
      a  = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_txn(op, a, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
